// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem -- data-memory responder for the DMEM side of a single-cycle core.
//
// Big-endian word array with byte / half-word / word access. Loads are purely
// combinational. Stores commit on the rising clock edge. Stores that are
// misaligned or out of range are dropped and recorded in a sticky fault
// register. The fault register also captures the address of the first such
// store.
//
// Optional feature macro: DMEM_STATS_EN
//   defined   : store_count / fault_count are live 32-bit wrapping counters.
//   undefined : both ports are tied to 32'h0 and no counter flops exist.
//
// Ports (bit 0 is the MSB on every [0:31] bus):
//   clock               in   rising-edge clock
//   reset               in   asynchronous active-low reset
//   addr_to_mem         in   byte address
//   data_to_mem         in   store data; sub-word data is right-justified
//   write_enable_to_mem in   store this cycle
//   byte_to_mem         in   byte access (has priority over half-word)
//   half_word_to_mem    in   half-word access
//   sign_extend_to_mem  in   sign-extend sub-word loads
//   data_from_mem       out  load data (combinational)
//   fault_clear         in   clears the sticky fault flag
//   fault               out  sticky store-fault flag
//   fault_addr          out  address of the first faulting store
//   store_count         out  committed-store counter (DMEM_STATS_EN)
//   fault_count         out  faulting-store counter  (DMEM_STATS_EN)
//
// ADDR_WIDTH may be at most 30.
// ---------------------------------------------------------------------------
module data_mem #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr_to_mem,
  input  logic [0:31] data_to_mem,
  input  logic        write_enable_to_mem,
  input  logic        byte_to_mem,
  input  logic        half_word_to_mem,
  input  logic        sign_extend_to_mem,
  output logic [0:31] data_from_mem,
  input  logic        fault_clear,
  output logic        fault,
  output logic [0:31] fault_addr,
  output logic [0:31] store_count,
  output logic [0:31] fault_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [0:31]           r_mem [0:DEPTH-1];
  logic                  r_fault;
  logic [0:31]           r_fault_addr;

  logic [0:31]           w_off;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [0:1]            w_lane;
  logic [0:31]           w_word;
  logic [0:7]            w_byte;
  logic [0:15]           w_half;
  logic [0:31]           w_merged;
  logic                  w_aligned;
  logic                  w_good_store;
  logic                  w_bad_store;
  logic                  w_wr_en;

  // The offset is in range when (off >> 2) < DEPTH, which is the same as
  // off < 4*DEPTH. The compare is done at 33 bits so that ADDR_WIDTH=30
  // does not overflow.
  assign w_off      = addr_to_mem - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < (33'd4 << ADDR_WIDTH));
  assign w_idx      = w_off[30-ADDR_WIDTH +: ADDR_WIDTH];
  assign w_lane     = addr_to_mem[30:31];

  // An out-of-range read yields zero. This also zeroes every sub-word result.
  assign w_word = w_in_range ? r_mem[w_idx] : 32'h0;

  always_comb begin
    w_byte = 8'h00;
    case (w_lane)
      2'd0:    w_byte = w_word[0:7];
      2'd1:    w_byte = w_word[8:15];
      2'd2:    w_byte = w_word[16:23];
      default: w_byte = w_word[24:31];
    endcase
    w_half = addr_to_mem[30] ? w_word[16:31] : w_word[0:15];

    data_from_mem = w_word;
    if (byte_to_mem) begin
      data_from_mem = {{24{sign_extend_to_mem & w_byte[0]}}, w_byte};
    end else if (half_word_to_mem) begin
      data_from_mem = {{16{sign_extend_to_mem & w_half[0]}}, w_half};
    end
  end

  always_comb begin
    w_aligned = 1'b1;
    if (byte_to_mem) begin
      w_aligned = 1'b1;
    end else if (half_word_to_mem) begin
      w_aligned = ~addr_to_mem[31];
    end else begin
      w_aligned = (addr_to_mem[30:31] == 2'b00);
    end
  end

  // Read-modify-write merge: the untouched lanes come from the current word.
  always_comb begin
    w_merged = w_word;
    if (byte_to_mem) begin
      case (w_lane)
        2'd0:    w_merged[0:7]   = data_to_mem[24:31];
        2'd1:    w_merged[8:15]  = data_to_mem[24:31];
        2'd2:    w_merged[16:23] = data_to_mem[24:31];
        default: w_merged[24:31] = data_to_mem[24:31];
      endcase
    end else if (half_word_to_mem) begin
      if (addr_to_mem[30]) begin
        w_merged[16:31] = data_to_mem[16:31];
      end else begin
        w_merged[0:15]  = data_to_mem[16:31];
      end
    end else begin
      w_merged = data_to_mem;
    end
  end

  assign w_good_store = write_enable_to_mem & w_in_range & w_aligned;
  assign w_bad_store  = write_enable_to_mem & ~(w_in_range & w_aligned);
  // Stores are dropped while reset is held low. The array itself is never
  // cleared.
  assign w_wr_en      = w_good_store & reset;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // A new fault overrides a simultaneous clear. The captured address is kept
  // across a clear. It is overwritten only by the first fault after a clear,
  // or by a fault that arrives in the same cycle as a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'h0;
    end else if (w_bad_store) begin
      r_fault <= 1'b1;
      if (!r_fault || fault_clear) begin
        r_fault_addr <= addr_to_mem;
      end
    end else if (fault_clear) begin
      r_fault <= 1'b0;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

`ifdef DMEM_STATS_EN
  logic [0:31] r_store_count;
  logic [0:31] r_fault_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_store_count <= 32'h0;
      r_fault_count <= 32'h0;
    end else begin
      if (w_good_store) begin
        r_store_count <= r_store_count + 32'd1;
      end
      if (w_bad_store) begin
        r_fault_count <= r_fault_count + 32'd1;
      end
    end
  end

  assign store_count = r_store_count;
  assign fault_count = r_fault_count;
`else
  assign store_count = 32'h0;
  assign fault_count = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;
  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SPAN = 32'd4 << AW;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] din   = 32'h0;
  logic        we = 1'b0, bt = 1'b0, hw = 1'b0, sx = 1'b0, fc = 1'b0;
  logic [31:0] dout, faddr, scnt, fcnt;
  logic        flt;

  always #5 clock = ~clock;

  data_mem #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .addr_to_mem(addr), .data_to_mem(din),
    .write_enable_to_mem(we), .byte_to_mem(bt), .half_word_to_mem(hw),
    .sign_extend_to_mem(sx), .data_from_mem(dout), .fault_clear(fc),
    .fault(flt), .fault_addr(faddr), .store_count(scnt), .fault_count(fcnt)
  );

  // Reference model: plain word array plus written-flags, fault state and counters.
  logic [31:0] mdl [0:(1<<AW)-1];
  bit          wr  [0:(1<<AW)-1];
  bit          m_fault = 1'b0;
  logic [31:0] m_faddr = 32'h0;
  logic [31:0] m_sc    = 32'h0;
  logic [31:0] m_fcnt  = 32'h0;
  bit          chk_on  = 1'b0;
  int          n_cmp   = 0;
  int          n_err   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < SPAN;
  endfunction

  function automatic bit aligned(input logic [31:0] a, input logic b, input logic h);
    if (b) return 1'b1;
    if (h) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  // Returns 1 when the expected load value is known.
  function automatic bit exp_load(input logic [31:0] a, input logic b, input logic h,
                                  input logic s, output logic [31:0] v);
    logic [31:0] off, w;
    logic [7:0]  x8;
    logic [15:0] x16;
    int          idx;
    v   = 32'h0;
    off = a - BASE;
    if (off >= SPAN) return 1'b1;
    idx = int'(off >> 2);
    if (!wr[idx]) return 1'b0;
    w = mdl[idx];
    if (b) begin
      x8 = 8'(w >> (8 * (3 - int'(a[1:0]))));
      v  = {{24{s & x8[7]}}, x8};
    end else if (h) begin
      x16 = a[1] ? w[15:0] : w[31:16];
      v   = {{16{s & x16[15]}}, x16};
    end else begin
      v = w;
    end
    return 1'b1;
  endfunction

  always @(negedge reset) begin
    m_fault = 1'b0;
    m_faddr = 32'h0;
    m_sc    = 32'h0;
    m_fcnt  = 32'h0;
  end

  always @(posedge clock) begin : model_edge
    logic [31:0] off, w, mask, val;
    int          idx, sh;
    bit          bad;
    if (reset) begin
      bad = we && !(in_rng(addr) && aligned(addr, bt, hw));
      if (we && !bad) begin
        off = addr - BASE;
        idx = int'(off >> 2);
        w   = wr[idx] ? mdl[idx] : 32'h0;
        if (bt) begin
          sh = 8 * (3 - int'(addr[1:0]));
          mask = 32'hFF << sh;
          val  = {24'h0, din[7:0]} << sh;
          w = (w & ~mask) | val;
          // A partially written word is only fully known if it was known before.
          wr[idx] = wr[idx];
        end else if (hw) begin
          sh = addr[1] ? 0 : 16;
          mask = 32'hFFFF << sh;
          val  = {16'h0, din[15:0]} << sh;
          w = (w & ~mask) | val;
        end else begin
          w = din;
          wr[idx] = 1'b1;
        end
        mdl[idx] = w;
        m_sc = m_sc + 32'd1;
      end
      if (bad) begin
        m_fcnt = m_fcnt + 32'd1;
        if (!m_fault || fc) m_faddr = addr;
        m_fault = 1'b1;
      end else if (fc) begin
        m_fault = 1'b0;
      end
    end
  end

  always @(negedge clock) begin : compare
    logic [31:0] ev;
    if (chk_on) begin
      if (exp_load(addr, bt, hw, sx, ev)) chk("model_load", dout, ev);
      chk("model_fault", {31'h0, flt}, {31'h0, m_fault});
      chk("model_fault_addr", faddr, m_faddr);
`ifdef DMEM_STATS_EN
      chk("model_store_count", scnt, m_sc);
      chk("model_fault_count", fcnt, m_fcnt);
`else
      chk("model_store_count", scnt, 32'h0);
      chk("model_fault_count", fcnt, 32'h0);
`endif
    end
  end

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic b, input logic h, input logic s, input logic f);
    @(posedge clock);
    #2;
    addr = a; din = d; we = w; bt = b; hw = h; sx = s; fc = f;
    @(negedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      wr[i]  = 1'b0;
      mdl[i] = 32'h0;
    end
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_fault", {31'h0, flt}, 32'h0);
    chk("rst_fault_addr", faddr, 32'h0);
    chk("rst_store_count", scnt, 32'h0);
    chk("rst_fault_count", fcnt, 32'h0);
    chk_on = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;

    // Word store and the load-after-store timing.
    step(32'h10, 32'h1111_1111, 1, 0, 0, 0, 0);
    step(32'h10, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
    chk("t1_same_cycle_old", dout, 32'h1111_1111);
    step(32'h10, 32'h0, 0, 0, 0, 0, 0);
    chk("t1_word_load", dout, 32'hDEAD_BEEF);

    // Byte store and byte loads.
    step(32'h10, 32'h1122_3344, 1, 0, 0, 0, 0);
    step(32'h13, 32'h55AA_0080, 1, 1, 0, 0, 0);
    step(32'h10, 32'h0, 0, 0, 0, 0, 0);
    chk("t2_word_after_byte", dout, 32'h1122_3380);
    step(32'h13, 32'h0, 0, 1, 0, 1, 0);
    chk("t2_byte_signed", dout, 32'hFFFF_FF80);
    step(32'h13, 32'h0, 0, 1, 0, 0, 0);
    chk("t2_byte_unsigned", dout, 32'h0000_0080);
    step(32'h10, 32'h0, 0, 1, 0, 1, 0);
    chk("t2_byte0_signed", dout, 32'h0000_0011);

    // Half store and half loads.
    step(32'h10, 32'h1122_3344, 1, 0, 0, 0, 0);
    step(32'h12, 32'h9999_ABCD, 1, 0, 1, 0, 0);
    step(32'h10, 32'h0, 0, 0, 0, 0, 0);
    chk("t3_word_after_half", dout, 32'h1122_ABCD);
    step(32'h12, 32'h0, 0, 0, 1, 1, 0);
    chk("t3_half_signed_hi_lane", dout, 32'hFFFF_ABCD);
    step(32'h10, 32'h0, 0, 0, 1, 1, 0);
    chk("t3_half_signed_lo_lane", dout, 32'h0000_1122);
    step(32'h13, 32'h0, 0, 0, 1, 0, 0);
    chk("t3_half_misaligned_load", dout, 32'h0000_ABCD);

    // Faulting stores.
    step(32'h4, 32'hCAFE_F00D, 1, 0, 0, 0, 0);
    step(32'h6, 32'h1234_5678, 1, 0, 0, 0, 0);
    step(32'h4, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_word_unchanged", dout, 32'hCAFE_F00D);
    chk("t4_fault_set", {31'h0, flt}, 32'h1);
    chk("t4_fault_addr_first", faddr, 32'h6);
    step(32'h5000, 32'h1, 1, 0, 0, 0, 0);
    step(32'h5000, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_oor_load_zero", dout, 32'h0);
    chk("t4_fault_addr_kept", faddr, 32'h6);
    step(32'h9, 32'h2, 1, 0, 0, 0, 1);
    step(32'h4, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_clear_and_fault", {31'h0, flt}, 32'h1);
    chk("t4_fault_addr_recaptured", faddr, 32'h9);
    step(32'h4, 32'h0, 0, 0, 0, 0, 1);
    step(32'h4, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_cleared", {31'h0, flt}, 32'h0);
    chk("t4_addr_held_after_clear", faddr, 32'h9);
    step(32'h11, 32'h3, 1, 0, 1, 0, 0);
    step(32'hFFC, 32'h7777_8888, 1, 0, 0, 0, 0);
    chk("t4_half_misaligned_addr", faddr, 32'h11);
    step(32'hFFC, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_last_word", dout, 32'h7777_8888);
    step(32'h1000, 32'h0, 0, 0, 0, 0, 0);
    chk("t4_first_oor_word", dout, 32'h0);

    // Reset during a store while a fault is pending.
    @(posedge clock);
    #2;
    reset = 1'b0; addr = 32'h4; din = 32'hDEAD_DEAD; we = 1'b1; bt = 1'b0; hw = 1'b0; fc = 1'b0;
    @(negedge clock);
    #1;
    chk("t5_fault_reset", {31'h0, flt}, 32'h0);
    chk("t5_fault_addr_reset", faddr, 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b1; we = 1'b0;
    @(negedge clock);
    #1;
    chk("t5_array_preserved", dout, 32'hCAFE_F00D);

`ifdef DMEM_STATS_EN
    // Counter wrap and fault counting.
    @(posedge clock);
    #2;
    we = 1'b0;
    force dut.r_store_count = 32'hFFFF_FFFF;
    m_sc = 32'hFFFF_FFFF;
    #1 release dut.r_store_count;
    step(32'h20, 32'hAAAA_5555, 1, 0, 0, 0, 0);
    step(32'h20, 32'h0, 0, 0, 0, 0, 0);
    chk("t6_store_count_wrap", scnt, 32'h0);
    step(32'h22, 32'h1, 1, 0, 0, 0, 0);
    step(32'h20, 32'h0, 0, 0, 0, 0, 0);
    chk("t6_fault_count_inc", fcnt, 32'h1);
    chk("t6_store_count_same", scnt, 32'h0);
`endif

    step(32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
Data-memory responder on the DMEM side of the single-cycle processor. It consumes the processor's address, write-enable, byte/half-word/sign-extend qualifiers and store data, and returns load data in the same cycle. Stores commit on the clock edge. Faulting stores (misaligned or out of range) are suppressed and recorded in a sticky fault register that software-visible logic or the testbench can read.

Parameters:
ADDR_WIDTH, 10, log2 of word depth (1024 words = 4 KB).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
addr_to_mem  input  [0:31]  byte address; bit 31 is the LSB.
data_to_mem  input  [0:31]  store data; byte/half data is right-justified in [24:31]/[16:31].
write_enable_to_mem  input  1  store this cycle.
byte_to_mem  input  1  byte access.
half_word_to_mem  input  1  half-word access.
sign_extend_to_mem  input  1  sign-extend sub-word loads.
data_from_mem  output  [0:31]  load data, combinational.
fault_clear  input  1  clears the sticky fault.
fault  output  1  sticky store-fault flag.
fault_addr  output  [0:31]  address of the first faulting store.
store_count  output  [0:31]  committed-store counter (DMEM_STATS_EN only).
fault_count  output  [0:31]  faulting-store counter (DMEM_STATS_EN only).

Behaviour:
- Storage: 2**ADDR_WIDTH words, big-endian. Offset 0 is bits [0:7]; offset 3 is bits [24:31]. Contents are not reset.
- Index and range: off = addr_to_mem - BASE_ADDR; index = off >> 2; in range when index < 2**ADDR_WIDTH (unsigned compare).
- Size select: byte_to_mem has priority over half_word_to_mem; neither asserted means a word access.
- Alignment:
  - byte: always aligned.
  - half-word: addr[31] == 0.
  - word: addr[30:31] == 0.
- Load path (combinational, 0-cycle latency):
  - word: the full word; addr[30:31] ignored.
  - half: addr[30] == 0 selects bits [0:15], 1 selects [16:31]; result placed in [16:31].
  - byte: lane addr[30:31], result placed in [24:31].
  - Sub-word upper bits: sign-extended when sign_extend_to_mem=1, else zero.
  - Misaligned loads: no fault, low bits ignored as above.
  - Out-of-range loads: return 32'h0.
- Store path: commits at the rising edge when write_enable_to_mem=1, in range, aligned, and reset deasserted.
  - Byte store writes only lane addr[30:31] with data[24:31].
  - Half store writes only the selected half with data[16:31].
  - Other lanes are preserved.
- Load after store: a load in the same cycle as a store sees pre-store contents. The next cycle sees the new value.
- Fault register (edge-updated):
  - bad_store = write_enable_to_mem & (misaligned | out of range). The store is suppressed.
  - If bad_store: fault <= 1, and fault_addr <= addr_to_mem only if fault was 0 (first fault wins).
  - Else if fault_clear: fault <= 0; fault_addr holds its value.
  - bad_store together with fault_clear: the fault is set and fault_addr is recaptured.
- Reset (asynchronous, active-low):
  - fault=0, fault_addr=0, counters=0.
  - Stores presented while reset is low are dropped.
  - Reset mid-run does not alter array contents.
  - data_from_mem stays combinational from the array through reset.

Optional Feature:
DMEM_STATS_EN
- Defined:
  - store_count increments on each committed store.
  - fault_count increments on each bad_store.
  - Both are 32-bit, wrap 32'hFFFF_FFFF -> 0, are unaffected by fault_clear, and are cleared by reset.
- Undefined: both ports are driven to constant 32'h0 and no counter flops are built.

Test Plan:
1. Word store 32'hDEAD_BEEF @0x10, then word load @0x10 -> 32'hDEAD_BEEF. The same-cycle load returns the old value.
2. Byte store 8'h80 @0x13 over 32'h1122_3344 -> word reads 32'h1122_3380. Signed byte load @0x13 -> 32'hFFFF_FF80; unsigned -> 32'h0000_0080.
3. Half store 16'hABCD @0x12 over 32'h1122_3344 -> 32'h1122_ABCD. Signed half load @0x12 -> 32'hFFFF_ABCD; @0x10 -> 32'h0000_1122.
4. Word store @0x0000_0006 -> word unchanged, fault=1, fault_addr=0x6. A second bad store @0x5000 (out of range at ADDR_WIDTH=10) -> fault_addr stays 0x6. fault_clear plus bad store @0x9 in the same cycle -> fault=1, fault_addr=0x9.
5. Drive reset low during a store with fault set -> store dropped, fault=0, fault_addr=0, array contents preserved.
6. With DMEM_STATS_EN and store_count preloaded to 32'hFFFF_FFFF via forced stores: one good store -> store_count=0. One bad store -> fault_count increments by 1 and store_count is unchanged.
